pipemdu: RTL
============

Name: pipemdu

Overview:
- Multi-cycle multiply/divide sequencer for the EXE stage of the pipelined CPU.
- Owns the HI/LO registers and runs a radix-2 iterative multiply (shift-add) or restoring divide over WIDTH cycles.
- Raises a stall to the pipeline controller when a later EXE instruction needs HI/LO or the unit while an operation is still in flight.
- Sits beside the ALU.
  - Operands are the already-forwarded EXE values ea/eb.
  - The mfhi/mflo result is muxed into the EXE result path by the stage.

Parameters:
WIDTH, 32, operand/HI/LO width; iteration count equals WIDTH; only 32 is verified.

Ports:
clk      input   1      clock, rising edge
rst      input   1      asynchronous, active-high reset
ea       input   WIDTH  rs operand (dividend / multiplicand / mthi-mtlo source)
eb       input   WIDTH  rt operand (divisor / multiplier)
emdop    input   3      000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 treated as none
ereadhl  input   1      EXE instruction is mfhi or mflo
hi       output  WIDTH  HI register
lo       output  WIDTH  LO register
busy     output  1      operation in flight (state != IDLE)
stall    output  1      freeze IF/ID/EXE this cycle

Behaviour:
- Reset (async, any state): state=IDLE, count=0, hi=0, lo=0, busy=0, stall=0, all internal operand/accumulator registers cleared.
  - Reset mid-operation abandons the operation; HI/LO read 0.
- stall = busy & (ereadhl | emdop in {001..110}). Combinational.
  - Never asserted in IDLE.
  - The stalled instruction holds emdop/ea/eb stable until stall drops.
- States: IDLE, RUN, DONE.
- IDLE, emdop mult/multu/div/divu:
  - Latch |ea|, |eb| for signed ops (raw values for unsigned) and the signs of ea and eb.
  - Clear the accumulator, set count=0, go to RUN.
  - The accepting cycle does not stall; the instruction leaves EXE normally.
- IDLE, emdop mthi/mtlo: write ea into hi/lo at that edge. Single cycle, state stays IDLE.
- IDLE, emdop none: hold.
- RUN: one iteration per edge. count increments; after the iteration with count=WIDTH-1, go to DONE.
  - Multiply: 2*WIDTH-bit product register, add multiplicand to upper half when LSB=1, then shift right 1. Carry-out of the add is kept as the shift-in bit.
  - Divide: restoring. Shift {rem,quot} left 1, trial subtract WIDTH+1 bits; if non-negative keep it and set quot LSB=1.
- DONE: one cycle, then IDLE.
  - mult/multu: {hi,lo} = product; signed ops negate the 64-bit product if sa^sb.
  - div/divu: lo=quotient, hi=remainder. Signed: quotient negated if sa^sb, remainder negated if sa (remainder takes dividend sign).
  - Divide by zero (eb==0 at acceptance): lo=all ones, hi=original ea, no sign fixup.
  - Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. Natural result, no trap.
- Latency: op accepted in cycle T; busy in cycles T+1..T+WIDTH+1; hi/lo updated at the edge ending T+WIDTH+1. The first non-stalled HI/LO reader executes in T+WIDTH+2.
- Independent instructions (emdop none, ereadhl=0) flow without stall while busy.
- hi/lo change only at reset, mthi/mtlo in IDLE, and DONE.
- A second mul/div arriving while busy stalls and is accepted in the first IDLE cycle.

Test Plan:
- Reset, then multu ea=0xFFFFFFFF eb=0x00000002 with no followers -> busy for 33 cycles; hi=0x00000001, lo=0xFFFFFFFE after DONE edge.
- mult ea=0xFFFFFFFD (-3) eb=0x00000007 followed immediately by mflo (ereadhl=1) -> stall high exactly cycles T+1..T+33, low in T+34; lo=0xFFFFFFEB, hi=0xFFFFFFFF.
- div ea=0xFFFFFFF9 (-7) eb=0x00000002 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); divu same operands -> lo=0x7FFFFFFC, hi=0x00000001.
- divu ea=0x12345678 eb=0 -> lo=0xFFFFFFFF, hi=0x12345678; signed div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi 0xAAAA5555 in IDLE -> hi updated next edge, no stall. Then mult followed by mtlo (while busy) -> mtlo stalls until IDLE, then lo overwritten while hi holds the mult result.
- Assert rst at RUN cycle 10 of a mult -> hi=lo=0, busy=stall=0 immediately (asynchronous); the next mult after release completes correctly.

Source files
------------

// File: rtl/pipemdu.sv
// rtl/pipemdu.sv - iterative multiply/divide unit owning HI/LO for the EXE stage
// Radix-2 shift-add multiply and restoring divide, one bit per cycle over WIDTH cycles.
module pipemdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] ea,
  input  logic [WIDTH-1:0] eb,
  input  logic [2:0]       emdop,
  input  logic             ereadhl,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             stall
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic               div_q, div_d;
  logic               sa_q, sa_d;
  logic               sb_q, sb_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               op_signed, op_div, ea_neg, eb_neg;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH+1:0]   trial;
  logic [2*WIDTH-1:0] prod_neg;

  assign hi = hi_q;
  assign lo = lo_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    div_d   = div_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dz_d    = dz_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    busy  = (state_q != IDLE);
    stall = busy & (ereadhl | ((emdop != 3'd0) && (emdop != 3'd7)));

    op_signed = (emdop == 3'd1) || (emdop == 3'd3);
    op_div    = (emdop == 3'd3) || (emdop == 3'd4);
    ea_neg    = op_signed & ea[WIDTH-1];
    eb_neg    = op_signed & eb[WIDTH-1];
    abs_a     = ea_neg ? -ea : ea;
    abs_b     = eb_neg ? -eb : eb;

    // Carry out of the accumulate becomes the bit shifted into the top.
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + ({1'b0, mcand_q} & {(WIDTH+1){acc_q[0]}});
    trial    = {1'b0, acc_q[2*WIDTH-1:WIDTH-1]} - {2'b00, mcand_q};
    prod_neg = -acc_q;

    case (state_q)
      IDLE: begin
        if (emdop inside {3'd1, 3'd2, 3'd3, 3'd4}) begin
          div_d   = op_div;
          sa_d    = ea_neg;
          sb_d    = eb_neg;
          dz_d    = op_div && (eb == '0);
          mcand_d = op_div ? abs_b : abs_a;
          acc_d   = {{WIDTH{1'b0}}, (op_div ? abs_a : abs_b)};
          count_d = '0;
          state_d = RUN;
        end else if (emdop == 3'd5) begin
          hi_d = ea;
        end else if (emdop == 3'd6) begin
          lo_d = ea;
        end
      end
      RUN: begin
        if (div_q) begin
          acc_d = trial[WIDTH+1] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end else begin
          acc_d = {add_sum, acc_q[WIDTH-1:1]};
        end
        count_d = count_q + 1'b1;
        if (count_q == CW'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        if (div_q) begin
          // Divide by zero leaves quotient all ones; remainder fixup restores original ea.
          lo_d = dz_q ? '1 : ((sa_q ^ sb_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
          hi_d = sa_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = (sa_q ^ sb_q) ? prod_neg : acc_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      div_q   <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dz_q    <= 1'b0;
      mcand_q <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      div_q   <= div_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dz_q    <= dz_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule
